iic_slave_mem: RTL
==================

Name: iic_slave_mem

Overview:
- I2C responder (slave) for the EEPROM-style protocol driven by our I2C master: 7-bit device address, then 8- or 16-bit word address, then data bytes.
- Single-byte and sequential reads/writes, current-address read, repeated START.
- Translates bus traffic into a simple synchronous memory port so a register file or BRAM can pose as an EEPROM.
- Used for loopback testing of the master and as a board-level configuration target.

Parameters:
- SLAVE_ADDR, 7'h50, device address this block answers to.
- ADDR16, 1'b1, 1: two word-address bytes (MSB first); 0: one byte, mem_addr[15:8] held 0.
- FILT_LEN, 3, Clk cycles an SCL/SDA level must be stable before it is accepted (used only with the optional filter).

Ports:
- Clk  in  1  system clock (50 MHz); all logic on posedge.
- Rst  in  1  synchronous, active-high reset.
- IIC_SCL  in  1  bus clock from the master.
- IIC_SDA  inout  1  bus data; open-drain: the block drives 0 or releases to 'z', never drives 1.
- mem_addr  out  16  word address pointer.
- mem_wr_en  out  1  one-Clk write strobe.
- mem_wdata  out  8  write data, valid with mem_wr_en.
- mem_rd_en  out  1  one-Clk read strobe.
- mem_rdata  in  8  read data, valid exactly 1 Clk after mem_rd_en.
- busy  out  1  high from address-matched START until STOP.
- IIC_done  out  1  one-Clk pulse on STOP that ends an addressed transaction.

Behaviour:
- Reset values: SDA released, mem_addr=0, mem_wr_en=0, mem_wdata=0, mem_rd_en=0, busy=0, IIC_done=0, state IDLE. Rst mid-transfer releases SDA on the next Clk.
- Input conditioning:
  - 2-FF synchronizers on SCL and SDA.
  - scl_rise and scl_fall are single-cycle pulses from the synchronized SCL.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both have priority over data handling in every state.
- Timing rules:
  - Data is sampled on scl_rise, MSB first.
  - SDA changes only in the Clk after scl_fall.
  - ACK: pull SDA low from the scl_fall after bit 8 until the scl_fall after bit 9.
- States and transitions:
  - IDLE: wait for START, then DEVADDR.
  - DEVADDR: shift 8 bits. On match with {SLAVE_ADDR}, ACK and set busy. If R/W=0, go to WADDR_H when ADDR16=1, else WADDR_L. If R/W=1, go to RDATA. On mismatch, no ACK; go to IGNORE.
  - WADDR_H / WADDR_L: shift 8 bits, ACK, load the byte into mem_addr[15:8] or [7:0]. WADDR_H then WADDR_L; WADDR_L then WDATA.
  - WDATA: after the 8th bit, pulse mem_wr_en at mem_addr with mem_wdata = byte, ACK. mem_addr increments on the ACK scl_fall. Stay in WDATA.
  - RDATA: on entry, and after each master ACK, pulse mem_rd_en at the current mem_addr. Capture mem_rdata the next Clk into the shift register. Drive bit 7 at the scl_fall ending the ACK slot, shift one bit per scl_fall, release SDA for bit 9. On sampled ACK (0), increment mem_addr and repeat. On NACK (1), go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- START in any state: clear the bit counter and go to DEVADDR (repeated START; mem_addr is kept for a random read).
- STOP in any state: go to IDLE, release SDA, clear busy. Pulse IIC_done if busy was set.
- mem_addr arithmetic:
  - Increments wrap modulo 2^16 when ADDR16=1 (16'hFFFF to 0).
  - Wrap modulo 2^8 when ADDR16=0 (8'hFF to 0, upper byte stays 0).
- Current-address read: a read with no preceding address phase uses the retained mem_addr.
- Minimum Clk/SCL ratio is 16. Not supported: clock stretching, general call, 10-bit addressing.

Optional Feature:
- Macro: IIC_GLITCH_FILTER_EN.
- Defined: after synchronization, an SCL or SDA level change is accepted only once stable for FILT_LEN consecutive Clk cycles. Adds FILT_LEN cycles of detection latency; rejects pulses shorter than FILT_LEN.
- Undefined: synchronizer outputs are used directly and FILT_LEN is ignored.

Decomposition:
- Package iic_pkg holds:
  - The state enum (IDLE, DEVADDR, WADDR_H, WADDR_L, WDATA, RDATA, IGNORE).
  - Constants IIC_RW_WRITE=0 and IIC_RW_READ=1.
  - Constants ACK=0 and NACK=1.
- One sub-module: iic_line_cond, which handles synchronizer, optional filter, edge pulses and START/STOP detection, and is instantiated once for the bus pair.

Test Plan:
- Write 16-bit address: START, 0xA0, 0x12, 0x34, 0x5A, STOP -> four ACKs; mem_wr_en once with mem_addr=0x1234 and mem_wdata=0x5A; IIC_done pulses once.
- Random read: write address 0x1234, repeated START, 0xA1, master NACK, STOP. Memory model returns 0xC3 -> SDA bits 1100_0011; mem_rd_en at 0x1234.
- Sequential read with wrap: address 0xFFFF, read 3 bytes ACK,ACK,NACK -> mem_rd_en at 0xFFFF, 0x0000, 0x0001.
- Address mismatch: START, 0xA2 -> SDA stays released for all 9 bits; no mem strobes; busy=0; no IIC_done on STOP.
- Abort: STOP after 4 bits of a data byte -> no mem_wr_en; IDLE; SDA released. Then assert Rst during an ACK -> SDA released next Clk; mem_addr=0.
- Glitch filter: with IIC_GLITCH_FILTER_EN and FILT_LEN=3, a 2-Clk SCL pulse is ignored and the bit counter is unchanged. Without the macro, the same pulse advances the bit counter by one.

Source files
------------

// File: rtl/iic_pkg.sv
// Shared definitions for the iic_slave_mem I2C responder.
// Contents: responder state enum, R/W and ACK bit encodings, and the
// word-address increment helper (16-bit wrap, or 8-bit wrap with the
// upper byte held at zero).
package iic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEVADDR,
    WADDR_H,
    WADDR_L,
    WDATA,
    RDATA,
    IGNORE
  } iic_state_t;

  localparam logic IIC_RW_WRITE = 1'b0;
  localparam logic IIC_RW_READ  = 1'b1;
  localparam logic ACK          = 1'b0;
  localparam logic NACK         = 1'b1;

  function automatic logic [15:0] addr_inc(input logic [15:0] a, input logic addr16);
    if (addr16) return a + 16'd1;
    else        return {8'h00, a[7:0] + 8'd1};
  endfunction

endpackage

// File: rtl/iic_line_cond.sv
// Bus line conditioning for the I2C responder.
// Synchronizes SCL/SDA into the Clk domain, optionally filters short
// glitches, and produces single-cycle SCL edge and START/STOP pulses.
// Optional feature macro: IIC_GLITCH_FILTER_EN (level accepted only after
// FILT_LEN consecutive stable cycles).
// Ports:
//   Clk, Rst          system clock, synchronous active-high reset
//   scl_i, sda_i      raw bus levels
//   sda_o             conditioned SDA level
//   scl_rise_o/fall_o one-cycle SCL edge pulses
//   start_o/stop_o    one-cycle START / STOP pulses
module iic_line_cond #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic Clk,
  input  logic Rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_lvl, sda_lvl;
  logic       scl_prev_q, sda_prev_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
    end
  end

`ifdef IIC_GLITCH_FILTER_EN
  localparam int unsigned CW = $clog2(FILT_LEN + 1);

  logic [CW-1:0] scl_cnt_q, sda_cnt_q;
  logic          scl_flt_q, sda_flt_q;

  // A differing level must persist FILT_LEN cycles; any return to the
  // accepted level restarts the count.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      scl_cnt_q <= '0;
      sda_cnt_q <= '0;
      scl_flt_q <= 1'b1;
      sda_flt_q <= 1'b1;
    end else begin
      if (scl_sync_q[1] == scl_flt_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == CW'(FILT_LEN - 1)) begin
        scl_flt_q <= scl_sync_q[1];
        scl_cnt_q <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + 1'b1;
      end

      if (sda_sync_q[1] == sda_flt_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == CW'(FILT_LEN - 1)) begin
        sda_flt_q <= sda_sync_q[1];
        sda_cnt_q <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + 1'b1;
      end
    end
  end

  assign scl_lvl = scl_flt_q;
  assign sda_lvl = sda_flt_q;
`else
  localparam int unsigned filt_len_unused = FILT_LEN;

  assign scl_lvl = scl_sync_q[1];
  assign sda_lvl = sda_sync_q[1];
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_lvl;
      sda_prev_q <= sda_lvl;
    end
  end

  assign sda_o      = sda_lvl;
  assign scl_rise_o = scl_lvl & ~scl_prev_q;
  assign scl_fall_o = ~scl_lvl & scl_prev_q;
  // SCL must be high on both samples so an SCL edge is never read as START/STOP.
  assign start_o    = scl_lvl & scl_prev_q & sda_prev_q & ~sda_lvl;
  assign stop_o     = scl_lvl & scl_prev_q & ~sda_prev_q & sda_lvl;

endmodule

// File: rtl/iic_slave_mem.sv
// EEPROM-style I2C responder bridging bus traffic to a synchronous memory port.
// 7-bit device address, 8/16-bit word address, single and sequential
// reads/writes, current-address read, repeated START.
// Optional feature macro: IIC_GLITCH_FILTER_EN (see iic_line_cond).
// Ports:
//   Clk, Rst      system clock, synchronous active-high reset
//   IIC_SCL       bus clock from master
//   IIC_SDA       open-drain bus data (drives 0 or z)
//   mem_addr      word address pointer
//   mem_wr_en     one-Clk write strobe, mem_wdata valid with it
//   mem_rd_en     one-Clk read strobe, mem_rdata valid 1 Clk later
//   busy          address-matched START until STOP
//   IIC_done      one-Clk pulse on STOP ending an addressed transaction
module iic_slave_mem #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter bit          ADDR16     = 1'b1,
  parameter int unsigned FILT_LEN   = 3
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        IIC_SCL,
  inout  logic        IIC_SDA,
  output logic [15:0] mem_addr,
  output logic        mem_wr_en,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        IIC_done
);
  import iic_pkg::*;

  logic sda, scl_rise, scl_fall, start, stop;

  iic_line_cond #(.FILT_LEN(FILT_LEN)) u_line_cond (
    .Clk        (Clk),
    .Rst        (Rst),
    .scl_i      (IIC_SCL),
    .sda_i      (IIC_SDA),
    .sda_o      (sda),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop)
  );

  iic_state_t  state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        sda_oe_q, sda_oe_d;
  logic [15:0] addr_q, addr_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rd_en_q, rd_en_d;
  logic        cap_q, cap_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ack_q, ack_d;
  logic        rw_q, rw_d;
  logic        mack_q, mack_d;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sda_oe_q  <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wdata_q   <= '0;
      rd_en_q   <= 1'b0;
      cap_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      rw_q      <= IIC_RW_WRITE;
      mack_q    <= NACK;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sda_oe_q  <= sda_oe_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wdata_q   <= wdata_d;
      rd_en_q   <= rd_en_d;
      cap_q     <= cap_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
      rw_q      <= rw_d;
      mack_q    <= mack_d;
    end
  end

  // bit_cnt counts SCL rises in a frame: 1..8 are data bits, 9 is the ACK
  // slot. The ACK decision is taken at the fall with count 8 and the frame
  // closes at the fall with count 9.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sda_oe_d  = sda_oe_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wdata_d   = wdata_q;
    rd_en_d   = 1'b0;
    cap_d     = rd_en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_d     = ack_q;
    rw_d      = rw_q;
    mack_d    = mack_q;

    if (cap_q) shift_d = mem_rdata;

    if (stop) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      done_d    = busy_q;
    end else if (start) begin
      state_d   = DEVADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (state_q != IDLE && state_q != IGNORE) begin
      if (scl_rise) begin
        if (bit_cnt_q < 4'd8) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (state_q != RDATA) shift_d = {shift_q[6:0], sda};
        end else if (bit_cnt_q == 4'd8) begin
          bit_cnt_d = 4'd9;
          if (state_q == RDATA) begin
            mack_d = sda;
            // Fetch the next byte now so it is loaded before the ACK slot ends.
            if (sda == ACK) begin
              addr_d  = addr_inc(addr_q, ADDR16);
              rd_en_d = 1'b1;
            end
          end
        end
      end else if (scl_fall) begin
        if (state_q == RDATA) begin
          if (bit_cnt_q >= 4'd1 && bit_cnt_q <= 4'd7) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end else if (bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
          end else if (bit_cnt_q == 4'd9) begin
            bit_cnt_d = '0;
            if (mack_q == ACK) begin
              sda_oe_d = ~shift_q[7];
            end else begin
              sda_oe_d = 1'b0;
              state_d  = IGNORE;
            end
          end
        end else if (bit_cnt_q == 4'd8) begin
          ack_d = 1'b1;
          unique case (state_q)
            DEVADDR: begin
              if (shift_q[7:1] == SLAVE_ADDR) begin
                rw_d     = shift_q[0];
                sda_oe_d = 1'b1;
                busy_d   = 1'b1;
                if (shift_q[0] == IIC_RW_READ) rd_en_d = 1'b1;
              end else begin
                ack_d = 1'b0;
              end
            end
            WADDR_H: begin
              addr_d[15:8] = shift_q;
              sda_oe_d     = 1'b1;
            end
            WADDR_L: begin
              addr_d[7:0] = shift_q;
              sda_oe_d    = 1'b1;
            end
            WDATA: begin
              wr_en_d  = 1'b1;
              wdata_d  = shift_q;
              sda_oe_d = 1'b1;
            end
            default: ;
          endcase
        end else if (bit_cnt_q == 4'd9) begin
          bit_cnt_d = '0;
          sda_oe_d  = 1'b0;
          unique case (state_q)
            DEVADDR: begin
              if (!ack_q) begin
                state_d = IGNORE;
              end else if (rw_q == IIC_RW_READ) begin
                state_d  = RDATA;
                sda_oe_d = ~shift_q[7];
              end else begin
                state_d = ADDR16 ? WADDR_H : WADDR_L;
              end
            end
            WADDR_H: state_d = WADDR_L;
            WADDR_L: state_d = WDATA;
            WDATA:   addr_d  = addr_inc(addr_q, ADDR16);
            default: ;
          endcase
        end
      end
    end
  end

  assign IIC_SDA   = sda_oe_q ? 1'b0 : 1'bz;
  assign mem_addr  = addr_q;
  assign mem_wr_en = wr_en_q;
  assign mem_wdata = wdata_q;
  assign mem_rd_en = rd_en_q;
  assign busy      = busy_q;
  assign IIC_done  = done_q;

endmodule
